// File: rtl/alarm_keypad_front.sv
// Input conditioning for the alarm FSM: synchronises and debounces the sensor
// contacts and keypad strobe, then runs the 4-digit code-entry state machine.
module alarm_keypad_front #(
  parameter int unsigned  NUM_SENSORS    = 2,
  parameter int unsigned  DEB_CYCLES     = 4,
  parameter logic [15:0]  CODE           = 16'h1234,
  parameter int unsigned  KEY_TIMEOUT    = 1000,
  parameter int unsigned  MAX_FAILS      = 3,
  parameter int unsigned  LOCKOUT_CYCLES = 2000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SENSORS-1:0] sensor_raw,
  input  logic                   key_strobe_raw,
  input  logic [3:0]             key_code,
  input  logic [1:0]             state_in,
  output logic                   sensor_trip,
  output logic                   arm_pulse,
  output logic                   disarm_pulse,
  output logic                   code_fail_pulse,
  output logic                   tamper_pulse,
  output logic                   lockout,
  output logic [2:0]             digit_count,
  output logic                   entry_busy
);

  localparam int unsigned NCH = NUM_SENSORS + 1;
  localparam int unsigned TW  = $clog2(KEY_TIMEOUT + 1);
  localparam int unsigned LW  = $clog2(LOCKOUT_CYCLES + 1);
  localparam int unsigned FW  = $clog2(MAX_FAILS + 1);

  localparam logic [15:0]   DEB_LAST  = 16'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(KEY_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_LOCKOUT
  } state_t;

  logic [NUM_SENSORS-1:0] sens_s1_q, sens_s2_q;
  logic                   strb_s1_q, strb_s2_q;
  logic [3:0]             key_s1_q, key_s2_q;

  // Channel NUM_SENSORS is the keypad strobe; lower channels are sensors.
  logic [NCH-1:0] sync_all;
  logic [NCH-1:0] deb_q, deb_d;
  logic [15:0]    deb_cnt_q [NCH];
  logic [15:0]    deb_cnt_d [NCH];

  state_t        state_q, state_d;
  logic [15:0]   buf_q, buf_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [FW-1:0] fail_q, fail_d;

  logic key_fire, is_digit, is_clr, is_ent;
  logic arm_d, disarm_d, fail_p_d;

  assign sync_all = {strb_s2_q, sens_s2_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      sens_s1_q <= '0;
      sens_s2_q <= '0;
      strb_s1_q <= 1'b0;
      strb_s2_q <= 1'b0;
      key_s1_q  <= '0;
      key_s2_q  <= '0;
    end else begin
      sens_s1_q <= sensor_raw;
      sens_s2_q <= sens_s1_q;
      strb_s1_q <= key_strobe_raw;
      strb_s2_q <= strb_s1_q;
      key_s1_q  <= key_code;
      key_s2_q  <= key_s1_q;
    end
  end

  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      deb_cnt_d[i] = '0;
      if (sync_all[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // A key is taken on the cycle the debounced strobe flips high, using the synced code.
  assign key_fire = deb_d[NUM_SENSORS] & ~deb_q[NUM_SENSORS];
  assign is_digit = (key_s2_q <= 4'd9);
  assign is_clr   = (key_s2_q == 4'hC);
  assign is_ent   = (key_s2_q == 4'hE);

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    lock_d   = lock_q;
    fail_d   = fail_q;
    arm_d    = 1'b0;
    disarm_d = 1'b0;
    fail_p_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_fire && is_digit) begin
          buf_d   = {12'h000, key_s2_q};
          cnt_d   = 3'd1;
          tmo_d   = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (key_fire && is_digit) begin
          buf_d = {buf_q[11:0], key_s2_q};
          if (cnt_q != 3'd5) begin
            cnt_d = cnt_q + 3'd1;
          end
          tmo_d = '0;
        end else if (key_fire && is_clr) begin
          buf_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else if (key_fire && is_ent) begin
          tmo_d   = '0;
          state_d = S_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          buf_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_CHECK: begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
        if (cnt_q == 3'd4 && buf_q == CODE) begin
          if (state_in == 2'b00) begin
            arm_d = 1'b1;
          end else begin
            disarm_d = 1'b1;
          end
          fail_d = '0;
        end else begin
          fail_p_d = 1'b1;
          fail_d   = fail_q + FW'(1);
          if (fail_q >= FAIL_LAST) begin
            lock_d  = '0;
            state_d = S_LOCKOUT;
          end
        end
      end
      S_LOCKOUT: begin
        if (lock_q == LOCK_LAST) begin
          lock_d  = '0;
          fail_d  = '0;
          state_d = S_IDLE;
        end else begin
          lock_d = lock_q + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      lock_q  <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      lock_q  <= lock_d;
      fail_q  <= fail_d;
    end
  end

  assign sensor_trip     = |deb_q[NUM_SENSORS-1:0];
  assign arm_pulse       = arm_d;
  assign disarm_pulse    = disarm_d;
  assign code_fail_pulse = fail_p_d;
  assign tamper_pulse    = (state_q == S_LOCKOUT) && (lock_q == '0);
  assign lockout         = (state_q == S_LOCKOUT);
  assign entry_busy      = (state_q == S_COLLECT);
  assign digit_count     = (state_q == S_COLLECT) ? cnt_q : '0;

endmodule

// File: doc/alarm_keypad_front.md
Name: alarm_keypad_front

Overview:
Input-conditioning stage directly upstream of the alarm state machine (OFF/ARMED/TRIGGERED/ALARM_ON). It synchronises and debounces the raw intrusion sensors and keypad strobe, then runs a 4-digit code-entry FSM. It emits single-cycle arm/disarm/fail/tamper pulses and a level sensor_trip that the alarm FSM consumes; the alarm FSM's current state is fed back to choose between arm and disarm.

Parameters:
NUM_SENSORS, 2, number of raw sensor inputs
DEB_CYCLES, 4, consecutive stable cycles required to change a debounced level (1..65535)
CODE, 16'h1234, four BCD digits, MS nibble entered first
KEY_TIMEOUT, 1000, idle cycles in COLLECT before the entry is abandoned
MAX_FAILS, 3, consecutive failed entries that cause lockout
LOCKOUT_CYCLES, 2000, lockout duration in cycles

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
sensor_raw  in  NUM_SENSORS  asynchronous sensor contacts, 1 = tripped
key_strobe_raw  in  1  asynchronous keypad "key down"
key_code  in  4  asynchronous key value, stable while strobe high
state_in  in  2  alarm FSM state: 00 OFF, 01 ARMED, 10 TRIGGERED, 11 ALARM_ON
sensor_trip  out  1  OR of debounced sensors
arm_pulse  out  1  one-cycle, correct code while OFF
disarm_pulse  out  1  one-cycle, correct code while not OFF
code_fail_pulse  out  1  one-cycle, rejected entry
tamper_pulse  out  1  one-cycle, on entry to lockout
lockout  out  1  high throughout LOCKOUT
digit_count  out  3  digits collected, saturates at 5
entry_busy  out  1  high in COLLECT

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All outputs, counters and sync flops are 0 after reset; FSM is in IDLE. Reset asserted mid-entry or mid-lockout aborts it; no pulse is emitted.
- Sync: 2-flop synchroniser on each sensor_raw bit, key_strobe_raw and key_code.
- Debounce (per sensor and strobe): a per-channel counter increments while the synced value differs from the debounced value and clears otherwise. When it reaches DEB_CYCLES, the debounced value flips and the counter clears. Glitches shorter than DEB_CYCLES are rejected.
- Latency: raw edge to debounced/sensor_trip change = 2 + DEB_CYCLES cycles.
- Key accept: a key is accepted on the cycle the debounced strobe rises; the synced key_code is captured that cycle. The falling strobe does nothing.
- Key decode: 0-9 are digits; C = clear; E = enter; A, B, D and F are ignored (they do not restart the timeout).
- FSM states IDLE, COLLECT, CHECK, LOCKOUT:
  - IDLE: a digit loads the buffer, sets digit_count=1 and goes to COLLECT. C or E in IDLE is ignored.
  - COLLECT: a digit shifts the buffer left by one nibble and increments digit_count (saturates at 5; 5 means overlong). C clears the buffer and count and returns to IDLE without a fail. E goes to CHECK. Each accepted digit/C/E reloads the timeout counter; after KEY_TIMEOUT cycles with no key, clear and return to IDLE with no fail.
  - CHECK (one cycle):
    - Success requires digit_count==4 and buffer==CODE. On success, fire arm_pulse if state_in==00, else disarm_pulse, and clear the fail counter.
    - Otherwise fire code_fail_pulse and increment the fail counter.
    - Pulses occur the cycle after E is accepted.
    - Clear buffer and count. Next state is LOCKOUT if the fail counter reaches MAX_FAILS, else IDLE.
  - LOCKOUT: tamper_pulse on the first cycle; lockout held high for LOCKOUT_CYCLES cycles. All keys are ignored, and the strobe debounce keeps running. On exit, clear the fail counter and go to IDLE.
- sensor_trip is independent of the FSM and continues through lockout.
- At most one of arm/disarm/code_fail pulses per cycle.
- entry_busy = (state==COLLECT); digit_count reads 0 outside COLLECT.

Test Plan:
- Reset: rst high 3 cycles, random inputs -> all outputs 0; after release, sensor_raw[0] 0->1 held -> sensor_trip rises exactly 6 cycles later (DEB_CYCLES=4).
- Glitch: sensor_raw[1] high for 3 cycles, and a strobe pulse of 3 cycles -> no sensor_trip, no key accepted.
- Arm/disarm: state_in=00, keys 1,2,3,4,E -> single arm_pulse; state_in=01, same sequence -> single disarm_pulse; fail counter is 0 afterwards.
- Failures/lockout: keys 1,2,3,5,E three times -> code_fail_pulse x3; tamper_pulse on the third; lockout high 2000 cycles; keys 1,2,3,4,E during lockout -> no pulses; correct code after exit -> arm_pulse.
- Length/clear/timeout:
  - 1,2,3,4,5,E -> fail (digit_count reached 5).
  - 1,2,3,E -> fail.
  - 9,C,1,2,3,4,E -> arm_pulse.
  - 1,2, wait 1000 cycles, 3,4,E -> fail (entry restarted from digit 3).
- Reset mid-entry: 1,2,3, rst 1 cycle, 4,E -> fail, no arm_pulse.
